// File: rtl/pulse_pkg.sv
// Shared constants for the pulse-to-held-request converter: FSM encoding and parameter defaults.
package pulse_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t HIGH = 2'b01;
  localparam state_t GAP  = 2'b10;

  localparam int DEF_CNT_WIDTH      = 4;
  localparam int DEF_MIN_HIGH       = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/pulse_req_hold_sat_updown_cnt.sv
// Saturating up/down counter; sat_hit_o flags an increment that was dropped at the ceiling.
module sat_updown_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             sat_hit_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && count_q != CNT_MAX) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign sat_hit_o = inc_i && !dec_i && (count_q == CNT_MAX);

endmodule

// File: rtl/pulse_req_hold.sv
// Turns single-cycle event pulses into a held request level released by ack, queueing extra pulses.
// Define PULSE_REQ_HOLD_TIMEOUT_EN to add TIMEOUT_CYCLES, the timeout_err output and a HIGH-state timeout.
module pulse_req_hold
  import pulse_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
`ifdef PULSE_REQ_HOLD_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
  parameter int MIN_HIGH  = DEF_MIN_HIGH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pulse_in,
  input  logic                 ack,
  output logic                 req_level,
  output logic [CNT_WIDTH-1:0] pending_cnt,
  output logic                 busy,
  output logic                 overflow
`ifdef PULSE_REQ_HOLD_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int HC_W = $clog2(MIN_HIGH + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(MIN_HIGH - 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(MIN_HIGH);

  state_t          state_q, state_d;
  logic            req_q;
  logic [HC_W-1:0] high_cnt_q, high_cnt_d;
  logic            ack_seen_q, ack_seen_d;
  logic            overflow_q;
  logic            q_inc, q_dec, sat_hit, pend_nz;
  logic            ack_any, timeout_hit, leave_high;

  sat_updown_cnt #(
    .WIDTH(CNT_WIDTH)
  ) u_pending (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .inc_i    (q_inc),
    .dec_i    (q_dec),
    .count_o  (pending_cnt),
    .sat_hit_o(sat_hit)
  );

  assign pend_nz    = |pending_cnt;
  assign ack_any    = ack | ack_seen_q;
  // An ack or timeout only releases the request once the minimum high time has elapsed.
  assign leave_high = (state_q == HIGH) && (ack_any || timeout_hit) && (high_cnt_q >= HC_LAST);

`ifdef PULSE_REQ_HOLD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            terr_q;

  assign timeout_hit = (state_q == HIGH) && (to_cnt_q >= TO_LAST);

  always_comb begin
    to_cnt_d = '0;
    if (state_q == HIGH) begin
      to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      terr_q   <= leave_high && !ack_any;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    ack_seen_d = ack_seen_q;
    q_inc      = 1'b0;
    q_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d    = HIGH;
          high_cnt_d = '0;
          ack_seen_d = 1'b0;
        end
      end
      HIGH: begin
        q_inc = pulse_in;
        if (leave_high) begin
          state_d    = GAP;
          high_cnt_d = '0;
          ack_seen_d = 1'b0;
        end else begin
          if (high_cnt_q != HC_MAX) high_cnt_d = high_cnt_q + HC_W'(1);
          if (ack) ack_seen_d = 1'b1;
        end
      end
      GAP: begin
        if (pend_nz) begin
          state_d = HIGH;
          q_dec   = 1'b1;
          q_inc   = pulse_in;
        end else if (pulse_in) begin
          state_d = HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      high_cnt_q <= '0;
      ack_seen_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d == HIGH);
      high_cnt_q <= high_cnt_d;
      ack_seen_q <= ack_seen_d;
      overflow_q <= overflow_q | sat_hit;
    end
  end

  assign req_level = req_q;
  assign busy      = (state_q != IDLE) || pend_nz;
  assign overflow  = overflow_q;

endmodule

// File: doc/pulse_req_hold.md
Name: pulse_req_hold

Overview:
- Inverse companion to the edge-to-pulse generator.
- Converts single-cycle event pulses into a held request level, and holds it until the consumer acknowledges.
- Queues further pulses that arrive while a request is outstanding.
- Sits between fast-domain control logic (SYS_CTRL events, FIFO pops) and a slow or level-sensitive consumer, e.g. a UART TX start or the input of a synchronizer.
- Guarantees at least one low cycle between requests, so a downstream edge detector sees every request.

Parameters:
- CNT_WIDTH, 4: width of the pending-request counter. Saturates at 2^CNT_WIDTH-1 (15).
- MIN_HIGH, 2: minimum number of cycles req_level stays high per request. Legal range is >=1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-low reset.
- pulse_in  in  1  single-cycle event. A level held high counts as one event per cycle.
- ack  in  1  consumer acknowledge, sampled on CLK.
- req_level  out  1  registered request level.
- pending_cnt  out  CNT_WIDTH  number of queued requests not yet issued.
- busy  out  1  high when state != IDLE or pending_cnt != 0.
- overflow  out  1  sticky; set when a pulse arrives while pending_cnt is saturated.

Behaviour:
- Reset: sampled on the CLK rising edge while RST=0. State=IDLE, req_level=0, pending_cnt=0, high_cnt=0, ack_seen=0, overflow=0. Reset mid-request drops req_level on that edge and discards the queue.
- Registers:
  - state is one of IDLE, HIGH, GAP.
  - high_cnt is a saturating cycle counter of width clog2(MIN_HIGH+1).
  - ack_seen is a 1-bit latch.
- IDLE, req_level=0:
  - pulse_in=1 -> HIGH on the same edge: req_level=1 next cycle (1-cycle latency). The pulse is not added to pending.
  - pending_cnt>0 in IDLE is unreachable.
- HIGH, req_level=1:
  - high_cnt increments each cycle.
  - ack=1 sets ack_seen.
  - Leave to GAP when (ack | ack_seen) and high_cnt >= MIN_HIGH-1. req_level=0 on that edge.
  - An ack arriving before MIN_HIGH is remembered, not lost.
  - high_cnt and ack_seen clear on entry to GAP.
- GAP, req_level=0, exactly 1 cycle:
  - pending_cnt>0 or pulse_in=1 -> HIGH. The issued request is taken from pending if pending>0, otherwise from pulse_in.
  - Otherwise -> IDLE.
- Pending counter, updated every cycle:
  - +1 if pulse_in is accepted into the queue. A pulse is queued in HIGH or GAP, except when it directly starts a request from GAP with pending=0.
  - -1 on a GAP->HIGH issue taken from pending.
  - Simultaneous +1 and -1 leaves the count unchanged.
  - Increment at 15 keeps the count at 15 and sets overflow. Overflow clears only on reset.
- ack outside HIGH is ignored.
- req_level is driven straight from a flop, with no combinational path from inputs.
- Throughput: back-to-back requests with immediate ack give a period of MIN_HIGH+1 cycles.

Optional Feature:
- Macro: PULSE_REQ_HOLD_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 255) and output timeout_err (1 bit).
  - In HIGH, a timeout counter runs. When it reaches TIMEOUT_CYCLES-1 without a qualifying ack, the FSM goes to GAP as if acked.
  - timeout_err pulses high for exactly one cycle, coincident with the first GAP cycle. Reset value 0.
  - The timeout counter clears on entry to HIGH.
- When undefined: HIGH waits for ack indefinitely, and neither the port nor the counter exists.

Decomposition:
- Shared package (pulse_pkg):
  - State encoding constants: IDLE=2'b00, HIGH=2'b01, GAP=2'b10.
  - Default CNT_WIDTH/MIN_HIGH/TIMEOUT_CYCLES constants.
- One natural sub-module: sat_updown_cnt.
  - Parameterized width; inputs inc and dec; outputs count and sat_hit.
  - Used for pending_cnt and reusable elsewhere.
- FSM, hold and timeout counters stay in the top.

Test Plan:
- Single pulse: pulse_in at cycle 5, ack at cycle 9.
  - Required: req_level high over cycles 6-9, low at 10.
  - busy drops at cycle 11 (one cycle after GAP); pending_cnt stays 0 throughout.
- Early ack: MIN_HIGH=4, ack high only in the first HIGH cycle -> req_level stays high exactly 4 cycles, then GAP.
- Burst: 3 pulses on consecutive cycles starting from IDLE, ack held high.
  - Required: pending_cnt peaks at 2.
  - req_level shows 3 high windows of MIN_HIGH cycles, each separated by exactly 1 low cycle.
  - pending_cnt returns to 0.
- Saturation: ack held 0, 17 pulses.
  - Required: pending_cnt=15 and overflow=1 after the 17th.
  - overflow stays 1 after the queue drains.
- Simultaneous: pulse_in=1 in the GAP cycle with pending=2 -> next HIGH starts and pending_cnt stays 2.
- Reset mid-HIGH with pending=3: RST=0 for one edge -> req_level=0, pending_cnt=0, overflow=0 on that edge. No request resumes.
- With PULSE_REQ_HOLD_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack:
  - req_level is high for 8 cycles.
  - timeout_err pulses one cycle at GAP.
  - The next pending request then issues.
